// File: rtl/td4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : td4_prog_loader
// Purpose  : Program memory and load/run controller for a TD4-class 4-bit CPU.
//            A byte-stream loader fills a 16x8 program memory. The CPU then
//            fetches combinationally from it through regPC. A small FSM
//            (IDLE / LOAD / RUN) sequences loading and supervises execution
//            through cpu_clr and cpu_en.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  single clock, rising edge
//   clr        in   1  synchronous active-high reset
//   ld_start   in   1  one-cycle pulse, begin a program load
//   ld_valid   in   1  loader byte valid
//   ld_data    in   8  program byte ([7:4] opcode, [3:0] immediate)
//   ld_ready   out  1  loader byte accept-ready (high only in LOAD)
//   run        in   1  level, free-run the CPU
//   step       in   1  one-cycle pulse, advance CPU one instruction
//   regPC      in   4  CPU program counter
//   CMD        out  4  opcode field of mem[regPC]
//   DATA       out  4  immediate field of mem[regPC]
//   cpu_clr    out  1  active-low CPU clear (released only in RUN)
//   cpu_en     out  1  registered CPU advance strobe
//   ld_done    out  1  one-cycle pulse after the 16th byte is accepted
//   state      out  2  FSM state: 0 IDLE, 1 LOAD, 2 RUN
//   checksum   out  8  modulo-256 sum of bytes accepted in the current load
// ----------------------------------------------------------------------------
// Build option
//   PROG_CHECKSUM_EN : when defined, checksum accumulates accepted bytes.
//                      When undefined, checksum is tied to 8'h00 and no adder
//                      is built.
// ============================================================================
module td4_prog_loader (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] regPC,
  output logic [3:0] CMD,
  output logic [3:0] DATA,
  output logic       cpu_clr,
  output logic       cpu_en,
  output logic       ld_done,
  output logic [1:0] state,
  output logic [7:0] checksum
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_RUN  = 2'd2;

  localparam logic [3:0] c_WPTR_LAST = 4'd15;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] wptr_q;
  logic [7:0] mem_q [16];
  logic       cpu_en_q;
  logic       ld_done_q;

  logic       w_ld_ready;
  logic       w_cpu_clr;
  logic       w_accept;
  logic       w_last;
  logic       w_load_entry;
  logic [7:0] w_fetch;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign w_accept     = ld_valid & w_ld_ready;
  assign w_last       = w_accept & (wptr_q == c_WPTR_LAST);
  // Entry into LOAD can come from IDLE or RUN; both restart the pointer.
  assign w_load_entry = (state_q != c_ST_LOAD) & (state_d == c_ST_LOAD);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        // A load request wins over a coincident run/step.
        if (ld_start) begin
          state_d = c_ST_LOAD;
        end else if (run | step) begin
          state_d = c_ST_RUN;
        end
      end
      c_ST_LOAD: begin
        // ld_start is deliberately ignored here; the load only ends on
        // the 16th accepted byte or on reset.
        if (w_last) begin
          state_d = c_ST_IDLE;
        end
      end
      c_ST_RUN: begin
        if (ld_start) begin
          state_d = c_ST_LOAD;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE on the next edge.
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_ld_ready = 1'b0;
    w_cpu_clr  = 1'b0;
    case (state_q)
      c_ST_LOAD: w_ld_ready = 1'b1;
      c_ST_RUN:  w_cpu_clr  = 1'b1;
      default: begin
        w_ld_ready = 1'b0;
        w_cpu_clr  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr_q <= 4'd0;
    end else if (w_load_entry) begin
      wptr_q <= 4'd0;
    end else if (w_accept) begin
      // The roll-over 15 -> 0 coincides with leaving LOAD, so it never
      // wraps inside a load.
      wptr_q <= wptr_q + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Program memory: reset-clearable register file, combinational read
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (w_accept) begin
      mem_q[wptr_q] <= ld_data;
    end
  end

  assign w_fetch = mem_q[regPC];
  assign CMD     = w_fetch[7:4];
  assign DATA    = w_fetch[3:0];

  // --------------------------------------------------------------------------
  // CPU advance strobe and load-done pulse
  // --------------------------------------------------------------------------
  // cpu_en is qualified by the state being entered, not the current state.
  // A step taken in IDLE therefore yields its strobe in the first RUN cycle.
  // A run/step coinciding with a load request in RUN yields no strobe, so
  // cpu_en is never seen outside RUN.
  always_ff @(posedge clk) begin
    if (clr) begin
      cpu_en_q  <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      cpu_en_q  <= (state_d == c_ST_RUN) & (run | step);
      ld_done_q <= w_last;
    end
  end

  // --------------------------------------------------------------------------
  // Optional load checksum
  // --------------------------------------------------------------------------
`ifdef PROG_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      checksum_q <= 8'h00;
    end else if (w_load_entry) begin
      checksum_q <= 8'h00;
    end else if (w_accept) begin
      checksum_q <= checksum_q + ld_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign ld_ready = w_ld_ready;
  assign cpu_clr  = w_cpu_clr;
  assign cpu_en   = cpu_en_q;
  assign ld_done  = ld_done_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_prog_loader
// Purpose  : Self-checking directed bench for td4_prog_loader. It applies a
//            table of FSM vectors and hand sequences for loads, clears and
//            run control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_prog_loader;

`ifdef PROG_CHECKSUM_EN
  localparam bit c_CK_ON = 1'b1;
`else
  localparam bit c_CK_ON = 1'b0;
`endif

  logic       clk;
  logic       clr;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       run;
  logic       step;
  logic [3:0] regPC;
  logic [3:0] CMD;
  logic [3:0] DATA;
  logic       cpu_clr;
  logic       cpu_en;
  logic       ld_done;
  logic [1:0] state;
  logic [7:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;

  td4_prog_loader u_dut (
    .clk      (clk),
    .clr      (clr),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .run      (run),
    .step     (step),
    .regPC    (regPC),
    .CMD      (CMD),
    .DATA     (DATA),
    .cpu_clr  (cpu_clr),
    .cpu_en   (cpu_en),
    .ld_done  (ld_done),
    .state    (state),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld_start;
    logic       ld_valid;
    logic       run;
    logic       step;
    logic [1:0] exp_state;
    logic       exp_rdy;
    logic       exp_clr;
    logic       exp_en;
    logic       exp_done;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      regPC = 4'(i);
      #1;
      check(name, {24'd0, CMD, DATA}, 32'd0);
    end
  endtask

  logic [7:0] loaded [16];
  logic [7:0] ck_model;
  logic [7:0] b;

  initial begin
    clr = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    run = 1'b0; step = 1'b0; regPC = 4'd0;

    // Vectors: ld_start, ld_valid, run, step | state, rdy, cpu_clr, cpu_en, done
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0}; // step: IDLE->RUN
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // valid ignored
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0}; // step 2
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0}; // step 3
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0}; // free run
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0}; // step during run
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // abort run -> LOAD
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // ld_start ignored in LOAD

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_state",    {30'd0, state}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_cpu_clr",  {31'd0, cpu_clr}, 32'd0);
    check("rst_cpu_en",   {31'd0, cpu_en}, 32'd0);
    check("rst_ld_done",  {31'd0, ld_done}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    check_mem_zero("rst_mem");
    clr = 1'b0;
    ld_data = 8'hAA;

    // ---------------- Table-driven FSM vectors ----------------
    for (int v = 0; v < 12; v++) begin
      ld_start = vecs[v].ld_start;
      ld_valid = vecs[v].ld_valid;
      run      = vecs[v].run;
      step     = vecs[v].step;
      tick();
      check($sformatf("vec%0d_state", v),   {30'd0, state},    {30'd0, vecs[v].exp_state});
      check($sformatf("vec%0d_ld_ready", v), {31'd0, ld_ready}, {31'd0, vecs[v].exp_rdy});
      check($sformatf("vec%0d_cpu_clr", v), {31'd0, cpu_clr},  {31'd0, vecs[v].exp_clr});
      check($sformatf("vec%0d_cpu_en", v),  {31'd0, cpu_en},   {31'd0, vecs[v].exp_en});
      check($sformatf("vec%0d_ld_done", v), {31'd0, ld_done},  {31'd0, vecs[v].exp_done});
    end
    ld_start = 1'b0; ld_valid = 1'b0; run = 1'b0; step = 1'b0;

    // ---------------- Load with ld_valid toggling ----------------
    ck_model = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 16 + (15 - i));
      loaded[i] = b;
      ck_model  = ck_model + b;
      ld_valid = 1'b1;
      ld_data  = b;
      tick();
      check($sformatf("tog_state_%0d", i), {30'd0, state}, (i == 15) ? 32'd0 : 32'd1);
      check($sformatf("tog_done_%0d", i), {31'd0, ld_done}, (i == 15) ? 32'd1 : 32'd0);
      regPC = 4'(i);
      ld_valid = 1'b0;
      ld_data  = 8'hFF;
      #1;
      check($sformatf("tog_visible_%0d", i), {24'd0, CMD, DATA}, {24'd0, b});
      tick();
      check($sformatf("tog_gap_done_%0d", i), {31'd0, ld_done}, 32'd0);
    end
    check("tog_idle", {30'd0, state}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      regPC = 4'(i);
      #1;
      check($sformatf("tog_mem_%0d", i), {24'd0, CMD, DATA}, {24'd0, loaded[i]});
    end
    check("tog_checksum", {24'd0, checksum}, c_CK_ON ? {24'd0, ck_model} : 32'd0);

    // ld_valid outside LOAD must not write
    regPC = 4'd0;
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    tick();
    check("idle_valid_rdy", {31'd0, ld_ready}, 32'd0);
    check("idle_valid_mem", {24'd0, CMD, DATA}, {24'd0, loaded[0]});
    ld_valid = 1'b0;

    // ---------------- Continuous load 0x30..0x3F, start wins over run/step --
    ld_start = 1'b1; run = 1'b1; step = 1'b1;
    tick();
    check("cont_entry_state", {30'd0, state}, 32'd1);
    check("cont_entry_rdy",   {31'd0, ld_ready}, 32'd1);
    check("cont_entry_en",    {31'd0, cpu_en}, 32'd0);
    check("cont_entry_ck",    {24'd0, checksum}, 32'd0);
    ld_start = 1'b0; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h30 + 8'(i);
      tick();
      check($sformatf("cont_done_%0d", i), {31'd0, ld_done}, (i == 15) ? 32'd1 : 32'd0);
    end
    ld_valid = 1'b0;
    check("cont_idle", {30'd0, state}, 32'd0);
    regPC = 4'd5;
    #1;
    check("cont_cmd5",  {28'd0, CMD}, 32'd3);
    check("cont_data5", {28'd0, DATA}, 32'd5);
    check("cont_checksum", {24'd0, checksum}, c_CK_ON ? 32'h78 : 32'd0);
    tick();
    check("cont_done_pulse_end", {31'd0, ld_done}, 32'd0);
    check("cont_checksum_held", {24'd0, checksum}, c_CK_ON ? 32'h78 : 32'd0);

    // ---------------- Clear after 7 accepted bytes ----------------
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h30 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    check("part_checksum", {24'd0, checksum}, c_CK_ON ? 32'h65 : 32'd0);
    check("part_state", {30'd0, state}, 32'd1);
    clr = 1'b1;
    tick();
    check("part_clr_state", {30'd0, state}, 32'd0);
    check("part_clr_done",  {31'd0, ld_done}, 32'd0);
    check("part_clr_ck",    {24'd0, checksum}, 32'd0);
    check("part_clr_rdy",   {31'd0, ld_ready}, 32'd0);
    clr = 1'b0;
    tick();
    check("part_after_done", {31'd0, ld_done}, 32'd0);
    check_mem_zero("part_mem");

    // ---------------- Clear while free-running ----------------
    run = 1'b1;
    tick();
    check("runclr_state", {30'd0, state}, 32'd2);
    check("runclr_en1",   {31'd0, cpu_en}, 32'd1);
    tick();
    check("runclr_en2",   {31'd0, cpu_en}, 32'd1);
    clr = 1'b1;
    tick();
    check("runclr_en_drop", {31'd0, cpu_en}, 32'd0);
    check("runclr_idle",    {30'd0, state}, 32'd0);
    check("runclr_cpu_clr", {31'd0, cpu_clr}, 32'd0);
    clr = 1'b0; run = 1'b0;
    tick();
    check("runclr_stay_idle", {30'd0, state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
